// File: rtl/dpi_timing_detect.sv
// rtl/dpi_timing_detect.sv - DPI receive timing measurement, coordinate recovery and lock
module dpi_timing_detect #(
  parameter logic        HS_POL      = 1'b1,
  parameter logic        VS_POL      = 1'b1,
  parameter int unsigned LOCK_FRAMES = 3,
  parameter int unsigned DATA_W      = 24
) (
  input  logic              pixel_clock,
  input  logic              reset_n,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              de_in,
  input  logic [DATA_W-1:0] rgb_in,
  output logic [DATA_W-1:0] rgb_out,
  output logic              de_out,
  output logic [11:0]       pixel_x,
  output logic [11:0]       line_y,
  output logic              line_start,
  output logic              frame_start,
  output logic [11:0]       h_total,
  output logic [11:0]       h_active,
  output logic [11:0]       v_total,
  output logic [11:0]       v_active,
  output logic              locked
);

  localparam logic [11:0] CNT_MAX = 12'hFFF;
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == CNT_MAX) ? v : v + 12'd1;
  endfunction

  // Stage 1 input registers and their one-clock history for edge detection
  logic              hs1_q, vs1_q, de1_q;
  logic              hs1p_q, vs1p_q, de1p_q;
  logic [DATA_W-1:0] rgb1_q;

  // Stage 2 output registers
  logic [DATA_W-1:0] rgb2_q;
  logic              de2_q;
  logic [11:0]       px_q, px_d;
  logic [11:0]       ly_q, ly_d;
  logic              ls_q, ls_d;
  logic              fs_q, fs_d;
  logic              fpend_q, fpend_d;

  // Free-running counters: clocks since hsync, DE run length, lines since vsync
  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] dcnt_q, dcnt_d;
  logic [11:0] hl_q, hl_d;
  logic [11:0] dl_q, dl_d;

  // Measurement registers
  logic [11:0] ht_q, ht_d;
  logic [11:0] ha_q, ha_d;
  logic [11:0] vt_q, vt_d;
  logic [11:0] va_q, va_d;

  // Lock FSM state
  state_e      state_q;
  logic [3:0]  match_q;
  logic [47:0] prev_q;
  logic        locked_q;

  logic        hs_edge, vs_edge, de_rise, de_fall;
  logic        h_to, v_to, timeout, h_mis;
  logic [11:0] ht_new;
  logic [47:0] frame_meas;
  logic [3:0]  match_inc;

  assign hs_edge = (hs1_q == HS_POL) && (hs1p_q != HS_POL);
  assign vs_edge = (vs1_q == VS_POL) && (vs1p_q != VS_POL);
  assign de_rise = de1_q && !de1p_q;
  assign de_fall = !de1_q && de1p_q;

  // Saturated counters mean a sync has disappeared; everything measured is stale
  assign h_to    = (hcnt_q == CNT_MAX);
  assign v_to    = (hl_q == CNT_MAX) || (dl_q == CNT_MAX);
  assign timeout = h_to || v_to;

  assign ht_new  = hcnt_q + 12'd1;
  // Line spacing changed mid-frame: no need to wait for vsync to drop lock
  assign h_mis   = hs_edge && (ht_new != ht_q);

  // Frame signature compared vsync-to-vsync; vertical values are the ones latched this edge
  assign frame_meas = {ht_q, ha_q, hl_q, dl_q};
  assign match_inc  = match_q + 4'd1;

  // Stage 1 capture of the raw DPI inputs
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      de1_q  <= 1'b0;
      hs1p_q <= 1'b0;
      vs1p_q <= 1'b0;
      de1p_q <= 1'b0;
      rgb1_q <= '0;
    end else begin
      hs1_q  <= hsync_in;
      vs1_q  <= vsync_in;
      de1_q  <= de_in;
      hs1p_q <= hs1_q;
      vs1p_q <= vs1_q;
      de1p_q <= de1_q;
      rgb1_q <= rgb_in;
    end
  end

  // Next-state for counters, measurements and stage 2 coordinates
  always_comb begin
    hcnt_d = hs_edge ? 12'd0 : sat_inc(hcnt_q);

    dcnt_d = dcnt_q;
    if (de_fall) begin
      dcnt_d = 12'd0;
    end else if (de1_q) begin
      dcnt_d = sat_inc(dcnt_q);
    end

    // An hsync or DE rise coincident with vsync belongs to the new frame
    hl_d = hl_q;
    dl_d = dl_q;
    if (vs_edge) begin
      hl_d = hs_edge ? 12'd1 : 12'd0;
      dl_d = de_rise ? 12'd1 : 12'd0;
    end else begin
      if (hs_edge) hl_d = sat_inc(hl_q);
      if (de_rise) dl_d = sat_inc(dl_q);
    end

    ht_d = ht_q;
    ha_d = ha_q;
    vt_d = vt_q;
    va_d = va_q;
    if (timeout) begin
      ht_d = 12'd0;
      ha_d = 12'd0;
      vt_d = 12'd0;
      va_d = 12'd0;
    end else begin
      if (hs_edge) ht_d = ht_new;
      if (de_fall) ha_d = dcnt_q;
      if (vs_edge) begin
        vt_d = hl_q;
        va_d = dl_q;
      end
    end

    px_d = px_q;
    if (de1_q) begin
      px_d = de_rise ? 12'd0 : sat_inc(px_q);
    end

    // Line index is the number of DE lines already seen this frame
    ly_d = ly_q;
    if (de_rise) begin
      ly_d = vs_edge ? 12'd0 : dl_q;
    end

    ls_d = de_rise;
    fs_d = de_rise && (fpend_q || vs_edge);

    fpend_d = fpend_q;
    if (de_rise) begin
      fpend_d = 1'b0;
    end else if (vs_edge) begin
      fpend_d = 1'b1;
    end
  end

  // Counter, measurement and stage 2 registers
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q  <= 12'd0;
      dcnt_q  <= 12'd0;
      hl_q    <= 12'd0;
      dl_q    <= 12'd0;
      ht_q    <= 12'd0;
      ha_q    <= 12'd0;
      vt_q    <= 12'd0;
      va_q    <= 12'd0;
      rgb2_q  <= '0;
      de2_q   <= 1'b0;
      px_q    <= 12'd0;
      ly_q    <= 12'd0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fpend_q <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      dcnt_q  <= dcnt_d;
      hl_q    <= hl_d;
      dl_q    <= dl_d;
      ht_q    <= ht_d;
      ha_q    <= ha_d;
      vt_q    <= vt_d;
      va_q    <= va_d;
      rgb2_q  <= rgb1_q;
      de2_q   <= de1_q;
      px_q    <= px_d;
      ly_q    <= ly_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      fpend_q <= fpend_d;
    end
  end

  // Lock FSM: timeout beats line-spacing change beats the per-frame comparison
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_SEARCH;
      match_q  <= 4'd0;
      prev_q   <= 48'd0;
      locked_q <= 1'b0;
    end else if (timeout) begin
      state_q  <= ST_SEARCH;
      match_q  <= 4'd0;
      prev_q   <= 48'd0;
      locked_q <= 1'b0;
    end else if (h_mis && (state_q != ST_SEARCH)) begin
      state_q  <= ST_SEARCH;
      match_q  <= 4'd0;
      locked_q <= 1'b0;
    end else if (vs_edge) begin
      prev_q <= frame_meas;
      case (state_q)
        ST_SEARCH: begin
          state_q <= ST_CHECK;
          match_q <= 4'd0;
        end
        ST_CHECK: begin
          if (frame_meas == prev_q) begin
            match_q <= match_inc;
            if (match_inc == LOCK_N) begin
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
            end
          end else begin
            match_q <= 4'd0;
          end
        end
        ST_LOCKED: begin
          if (frame_meas != prev_q) begin
            state_q  <= ST_SEARCH;
            match_q  <= 4'd0;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_SEARCH;
          match_q  <= 4'd0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign rgb_out     = rgb2_q;
  assign de_out      = de2_q;
  assign pixel_x     = px_q;
  assign line_y      = ly_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign h_total     = ht_q;
  assign h_active    = ha_q;
  assign v_total     = vt_q;
  assign v_active    = va_q;
  assign locked      = locked_q;

endmodule
